// File: rtl/reg64_serial_reader.sv
// Purpose: reads one word from a storage register and shifts it out bit-serially over valid/ready.
// Latency: Start@n -> read strobe n+1, capture n+2, first bit n+3, Done n+3+WIDTH (+1 with parity).
// Backpressure: i_sready low holds o_sout/o_svalid and the bit count; optional SER_PARITY_EN appends an even-parity bit.
module reg64_serial_reader #(
    parameter int WIDTH     = 64,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_reg_read,
    output logic             o_reg_en,
    output logic             o_sout,
    output logic             o_svalid,
    input  logic             i_sready,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SHIFT   = 3'd3,
        S_PARITY  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             w_fire;
    logic             w_last;
    logic             w_bit;

    // Bit presented to the consumer depends on shift direction.
    assign w_bit  = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    // Count reaches 1 on the final data bit, so it never wraps below zero.
    assign w_last = (r_cnt == CW'(1));

`ifdef SER_PARITY_EN
    logic r_par;

    // Parity of the captured word, taken at capture so later Din changes cannot affect it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_par <= 1'b0;
        end else if (r_state == S_CAPTURE) begin
            r_par <= ^i_din;
        end
    end
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs; the serial handshake only advances in data/parity states.
    always_comb begin
        w_next     = r_state;
        w_fire     = 1'b0;
        o_reg_read = 1'b0;
        o_reg_en   = 1'b0;
        o_sout     = 1'b0;
        o_svalid   = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                o_reg_read = 1'b1;
                o_reg_en   = 1'b1;
                o_busy     = 1'b1;
                w_next     = S_CAPTURE;
            end
            S_CAPTURE: begin
                o_busy = 1'b1;
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                o_busy   = 1'b1;
                o_svalid = 1'b1;
                o_sout   = w_bit;
                w_fire   = i_sready;
                if (i_sready && w_last) begin
`ifdef SER_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                o_busy   = 1'b1;
                o_svalid = 1'b1;
                o_sout   = r_par;
                if (i_sready) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Shift register and remaining-bit count: load on capture, advance one bit per accepted handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_shreg <= i_din;
            r_cnt   <= CNT_FULL;
        end else if (w_fire) begin
            if (MSB_FIRST) begin
                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            end else begin
                r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
            end
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_reg64_serial_reader.sv
// Bench for reg64_serial_reader: LSB-first and MSB-first instances share stimulus.
// Expected bit streams come from arithmetic on the word; latency checked against stall count.
// Random SReady backpressure and stray Start pulses; SER_PARITY_EN adds the parity bit.
module tb_reg64_serial_reader;

    localparam int W = 64;
`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sready;
    logic [W-1:0] din;

    logic a_rd, a_en, a_so, a_sv, a_busy, a_done;
    logic b_rd, b_en, b_so, b_sv, b_busy, b_done;

    int n_cmp = 0;
    int n_err = 0;

    bit exp_a[$];
    bit exp_b[$];

    always #5 clk = ~clk;

    reg64_serial_reader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_din(din),
        .o_reg_read(a_rd), .o_reg_en(a_en), .o_sout(a_so), .o_svalid(a_sv),
        .i_sready(sready), .o_busy(a_busy), .o_done(a_done)
    );

    reg64_serial_reader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_din(din),
        .o_reg_read(b_rd), .o_reg_en(b_en), .o_sout(b_so), .o_svalid(b_sv),
        .i_sready(sready), .o_busy(b_busy), .o_done(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frames: bit i of the word is (word >> i) & 1; parity is popcount mod 2.
    task automatic load(input logic [W-1:0] word);
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i < W; i++) begin
            exp_a.push_back(bit'((word >> i) & 64'd1));
            exp_b.push_back(bit'((word >> (W - 1 - i)) & 64'd1));
        end
        if (PAR == 1) begin
            exp_a.push_back(bit'($countones(word) % 2));
            exp_b.push_back(bit'($countones(word) % 2));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"},   {a_rd, b_rd},     2'b00);
        chk({tag, "_en"},   {a_en, b_en},     2'b00);
        chk({tag, "_sout"}, {a_so, b_so},     2'b00);
        chk({tag, "_sv"},   {a_sv, b_sv},     2'b00);
        chk({tag, "_busy"}, {a_busy, b_busy}, 2'b00);
        chk({tag, "_done"}, {a_done, b_done}, 2'b00);
    endtask

    // One full frame from an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic run_frame(input logic [W-1:0] word, input logic [W-1:0] din_after,
                             input bit hold, input int stall_at, input int stall_len,
                             input int stall_pct, input bit noise);
        int cyc;
        int stalls;
        int sent;
        int held;
        int guard;
        load(word);
        chk("idle_busy", {a_busy, b_busy}, 2'b00);
        din   = word;
        start = 1'b1;
        step();
        cyc = 1;
        chk("fetch_rd",   {a_rd, b_rd},     2'b11);
        chk("fetch_en",   {a_en, b_en},     2'b11);
        chk("fetch_busy", {a_busy, b_busy}, 2'b11);
        chk("fetch_sv",   {a_sv, b_sv},     2'b00);
        if (!hold) start = 1'b0;
        step();
        cyc = 2;
        chk("cap_rd",   {a_rd, b_rd},     2'b00);
        chk("cap_sv",   {a_sv, b_sv},     2'b00);
        chk("cap_busy", {a_busy, b_busy}, 2'b11);
        step();
        cyc = 3;
        din    = din_after;
        stalls = 0;
        sent   = 0;
        held   = 0;
        guard  = 0;
        while (exp_a.size() > 0 && guard < 2000) begin
            guard++;
            if (noise) start = 1'($urandom_range(0, 1));
            if (sent == stall_at && held < stall_len) begin
                sready = 1'b0;
                held++;
            end else begin
                sready = ($urandom_range(0, 99) >= stall_pct);
            end
            chk("sh_sv",   {a_sv, b_sv},     2'b11);
            chk("sh_lsb",  a_so,             exp_a[0]);
            chk("sh_msb",  b_so,             exp_b[0]);
            chk("sh_done", {a_done, b_done}, 2'b00);
            chk("sh_rd",   {a_rd, b_rd},     2'b00);
            chk("sh_busy", {a_busy, b_busy}, 2'b11);
            if (sready) begin
                void'(exp_a.pop_front());
                void'(exp_b.pop_front());
                sent++;
            end else begin
                stalls++;
            end
            step();
            cyc++;
        end
        chk("frame_bound", guard < 2000, 1);
        if (noise) start = 1'b1;
        chk("done_pulse", {a_done, b_done}, 2'b11);
        chk("done_busy",  {a_busy, b_busy}, 2'b11);
        chk("done_sv",    {a_sv, b_sv},     2'b00);
        chk("latency",    cyc,              3 + W + PAR + stalls);
        step();
        if (!hold) start = 1'b0;
        chk("post_busy", {a_busy, b_busy}, 2'b00);
        chk("post_done", {a_done, b_done}, 2'b00);
        chk("post_sv",   {a_sv, b_sv},     2'b00);
        if (noise) begin
            step();
            chk("noise_idle_busy", {a_busy, b_busy}, 2'b00);
            chk("noise_idle_rd",   {a_rd, b_rd},     2'b00);
        end
    endtask

    // Hard stop if the sequence ever stalls outright.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence with randomized words, backpressure and stray Start pulses.
    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sready = 1'b0;
        din    = '0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("idle");

        // Reset while shifting 64'h59 after 5 bits: word dropped, no Done.
        din   = 64'h59;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        sready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("mid_sv", {a_sv, b_sv}, 2'b11);
        chk("mid_lsb_bit5", a_so, 1'b0);
        rst = 1'b1;
        step();
        chk_all_zero("rst1");
        step();
        chk_all_zero("rst2");
        rst = 1'b0;
        step();
        chk_all_zero("after_rst");

        // 64'h59 straight through, then 64'h1 (parity / MSB-first last bit).
        run_frame(64'h59, {$urandom, $urandom}, 1'b0, -1, 0, 0, 1'b0);
        run_frame(64'h1,  {$urandom, $urandom}, 1'b0, -1, 0, 0, 1'b0);

        // Three-cycle stall on bit 2.
        run_frame(64'h59, {$urandom, $urandom}, 1'b0, 2, 3, 0, 1'b0);

        // Start held high: back-to-back frames; Din changed to FF after capture.
        run_frame(64'h59, 64'hFF, 1'b1, -1, 0, 0, 1'b0);
        run_frame(64'hFF, {$urandom, $urandom}, 1'b1, -1, 0, 0, 1'b0);
        run_frame({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, -1, 0, 0, 1'b0);

        // Random words, random backpressure, Start noise in SHIFT and DONE.
        for (int k = 0; k < 5; k++) begin
            run_frame({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, -1, 0, 30, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
